qupls_alu_seq: RTL and testbench
================================

QUPLS_ALU_SEQ -- requirements
Module: qupls_alu_seq

Interface
REQ-001 SHALL have parameter WID, default 64, operand/result width.
REQ-002 SHALL have parameter RIDW, default 5, reorder-buffer id width.
REQ-003 SHALL have parameter TIMEOUT, default 200, max WAIT cycles before forced completion.
REQ-004 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst  in  1  sync reset
- flush  in  1  discard in-flight op
- iss_valid  in  1  issue request
- iss_ready  out  1  sequencer idle
- iss_cls  in  alu_class_t  SINGLE/MUL/DIV
- iss_sgn  in  1  signed divide
- iss_ir  in  instruction_t  instruction
- iss_rid  in  RIDW  ROB id
- iss_a, iss_b, iss_c, iss_i  in  WID  operands
- alu_ld  out  1  one-cycle start pulse to ALU
- alu_div  out  1  registered iss_sgn
- alu_ir  out  instruction_t  registered iss_ir
- alu_a, alu_b, alu_c, alu_i  out  WID  registered operands
- alu_o  in  WID  ALU result
- alu_mul_done  in  1  multiply complete
- alu_div_done  in  1  divide complete
- alu_div_dbz  in  1  divide by zero
- alu_exc  in  cause_code_t  ALU exception
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_res  out  WID  result
- wb_rid  out  RIDW  ROB id
- wb_exc  out  cause_code_t  exception

Function
REQ-006 SHALL implement states IDLE, EXEC, WAIT, HOLD.
REQ-007 SHALL assert iss_ready only in IDLE; accept = iss_valid && iss_ready.
REQ-008 SHALL, on accept, register ir, operands, sgn, cls, rid, and enter EXEC.
REQ-009 SHALL drive alu_ld high exactly the single cycle spent in EXEC.
REQ-010 SHALL, for SINGLE in EXEC, capture alu_o and alu_exc at the clock edge and enter HOLD; wb_valid rises two cycles after accept.
REQ-011 SHALL, for MUL/DIV in EXEC, clear the wait counter and enter WAIT.
REQ-012 SHALL ignore alu_mul_done/alu_div_done while in EXEC (stale done from a prior op).
REQ-013 SHALL, in WAIT, capture on alu_mul_done (MUL) or alu_div_done (DIV) and enter HOLD; the done of the other class is ignored.
REQ-014 SHALL set wb_exc to FLT_DBZ when DIV completes with alu_div_dbz high, else the captured alu_exc.
REQ-015 SHALL increment an 8-bit wait counter each WAIT cycle; when the counter equals TIMEOUT-1 without done, enter HOLD with wb_res = {WID/16{16'hDEAD}} and wb_exc = FLT_ALU_TO.
REQ-016 SHALL give done priority over timeout in the same cycle.
REQ-017 SHALL hold wb_valid, wb_res, wb_rid and wb_exc stable in HOLD until wb_valid && wb_ready, then return to IDLE.
REQ-018 SHALL, on flush in any state, enter IDLE next cycle with wb_valid and alu_ld low; flush overrides accept and done in the same cycle.
REQ-019 SHALL drive alu_* operand outputs from registers only, with no combinational path from iss_* to alu_*.

Reset
REQ-020 SHALL, on rst, enter IDLE with iss_ready=1 after the edge, alu_ld=0, wb_valid=0, wait counter=0, and wb_exc=FLT_NONE.
REQ-021 SHALL zero all data registers on rst; rst mid-WAIT abandons the op with no writeback.

Structure
REQ-022 SHALL place alu_class_t (SINGLE=0, MUL=1, DIV=2) and cause code FLT_ALU_TO in QuplsPkg.
REQ-023 SHALL be a single module with no sub-modules; the qupls_alu instance is external.

Verification
REQ-024 SHALL cover SINGLE ADDI a=5, i=3, ALU returning 8: wb_valid at accept+2, wb_res=8, rid echoed.
REQ-025 SHALL cover MUL with mul_done four cycles after alu_ld: wb_valid the cycle after done; a done pulse during EXEC is ignored.
REQ-026 SHALL cover DIV with b=0 and div_done+dbz: wb_exc=FLT_DBZ.
REQ-027 SHALL cover DIV with no done and TIMEOUT=10: HOLD entered 10 cycles after entering WAIT, wb_res=16'hDEAD pattern, wb_exc=FLT_ALU_TO.
REQ-028 SHALL cover wb_ready low for 5 cycles: outputs stable, iss_ready low; ready=1 returns to IDLE.
REQ-029 SHALL cover flush asserted mid-WAIT with coincident done: no wb_valid, and iss_ready=1 the next cycle.

Source files
------------

// File: rtl/qupls_alu_seq_pkg.sv
// QuplsPkg: shared types for the Qupls ALU issue sequencer.
//   alu_class_t     - which completion protocol the issued op follows
//   cause_code_t    - exception cause reported with a writeback
//   instruction_t   - raw instruction word forwarded to the ALU
//   alu_seq_state_t - sequencer FSM states
package QuplsPkg;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2
    } alu_class_t;

    typedef enum logic [7:0] {
        FLT_NONE   = 8'h00,
        FLT_DBZ    = 8'h10,
        FLT_OFL    = 8'h11,
        FLT_ILL    = 8'h12,
        FLT_ALU_TO = 8'h3F
    } cause_code_t;

    typedef logic [31:0] instruction_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT,
        ST_HOLD
    } alu_seq_state_t;

endpackage

// File: rtl/qupls_alu_seq.sv
// qupls_alu_seq: issues one op at a time to an external qupls_alu and
// returns its result to writeback.
//   iss_*  : issue handshake (iss_valid/iss_ready) plus op class, sign,
//            instruction, ROB id and operands
//   alu_*  : registered operands and a one-cycle alu_ld start pulse out;
//            result, done strobes, divide-by-zero and exception in
//   wb_*   : result, ROB id and cause held until wb_valid && wb_ready
//   flush  : abandons whatever is in flight, back to idle next cycle
// SINGLE ops complete in the EXEC cycle. MUL/DIV wait for their own done
// strobe, bounded by TIMEOUT cycles after which a poison result is returned.
module qupls_alu_seq
    import QuplsPkg::*;
#(
    parameter int WID     = 64,
    parameter int RIDW    = 5,
    parameter int TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  alu_class_t        iss_cls,
    input  logic              iss_sgn,
    input  instruction_t      iss_ir,
    input  logic [RIDW-1:0]   iss_rid,
    input  logic [WID-1:0]    iss_a,
    input  logic [WID-1:0]    iss_b,
    input  logic [WID-1:0]    iss_c,
    input  logic [WID-1:0]    iss_i,
    output logic              alu_ld,
    output logic              alu_div,
    output instruction_t      alu_ir,
    output logic [WID-1:0]    alu_a,
    output logic [WID-1:0]    alu_b,
    output logic [WID-1:0]    alu_c,
    output logic [WID-1:0]    alu_i,
    input  logic [WID-1:0]    alu_o,
    input  logic              alu_mul_done,
    input  logic              alu_div_done,
    input  logic              alu_div_dbz,
    input  cause_code_t       alu_exc,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [WID-1:0]    wb_res,
    output logic [RIDW-1:0]   wb_rid,
    output cause_code_t       wb_exc
);

    localparam logic [7:0]     TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [WID-1:0] POISON  = {(WID/16){16'hDEAD}};

    alu_seq_state_t  state, state_nxt;
    alu_class_t      cls_r;
    logic [RIDW-1:0] rid_r;
    logic [7:0]      wait_cnt;

    logic accept;
    logic done_hit;
    logic to_hit;
    logic cap_single;

    // Only the done strobe matching the op's class counts; the other unit
    // may still be finishing something unrelated.
    assign done_hit = (cls_r == MUL && alu_mul_done) || (cls_r == DIV && alu_div_done);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        iss_ready  = 1'b0;
        alu_ld     = 1'b0;
        wb_valid   = 1'b0;
        accept     = 1'b0;
        to_hit     = 1'b0;
        cap_single = 1'b0;
        case (state)
            ST_IDLE: begin
                iss_ready = 1'b1;
                accept    = iss_valid && !flush;
                if (iss_valid)
                    state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                alu_ld = 1'b1;
                // Done strobes seen here belong to a previous op: not sampled.
                if (cls_r == SINGLE) begin
                    cap_single = !flush;
                    state_nxt  = ST_HOLD;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_hit) begin
                    state_nxt = ST_HOLD;
                end else if (wait_cnt == TO_LAST) begin
                    to_hit    = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                wb_valid = 1'b1;
                if (wb_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush)
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cls_r    <= SINGLE;
            rid_r    <= '0;
            alu_div  <= 1'b0;
            alu_ir   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_c    <= '0;
            alu_i    <= '0;
            wb_res   <= '0;
            wb_exc   <= FLT_NONE;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                cls_r   <= iss_cls;
                rid_r   <= iss_rid;
                alu_div <= iss_sgn;
                alu_ir  <= iss_ir;
                alu_a   <= iss_a;
                alu_b   <= iss_b;
                alu_c   <= iss_c;
                alu_i   <= iss_i;
            end
            if (state == ST_EXEC)
                wait_cnt <= '0;
            if (cap_single) begin
                wb_res <= alu_o;
                wb_exc <= alu_exc;
            end
            if (state == ST_WAIT && !flush) begin
                if (done_hit) begin
                    wb_res <= alu_o;
                    wb_exc <= (cls_r == DIV && alu_div_dbz) ? FLT_DBZ : alu_exc;
                end else if (to_hit) begin
                    wb_res <= POISON;
                    wb_exc <= FLT_ALU_TO;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

    assign wb_rid = rid_r;

endmodule

// File: tb/tb_qupls_alu_seq.sv
module tb_qupls_alu_seq;
    import QuplsPkg::*;

    localparam int T = 10;
    localparam int NEVER = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, iss_valid, iss_ready, iss_sgn;
    alu_class_t   iss_cls;
    instruction_t iss_ir, alu_ir;
    logic [4:0]   iss_rid, wb_rid;
    logic [63:0]  iss_a, iss_b, iss_c, iss_i;
    logic         alu_ld, alu_div;
    logic [63:0]  alu_a, alu_b, alu_c, alu_i, alu_o;
    logic         alu_mul_done, alu_div_done, alu_div_dbz;
    cause_code_t  alu_exc, wb_exc;
    logic         wb_valid, wb_ready;
    logic [63:0]  wb_res;

    qupls_alu_seq #(.WID(64), .RIDW(5), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_cls(iss_cls),
        .iss_sgn(iss_sgn), .iss_ir(iss_ir), .iss_rid(iss_rid),
        .iss_a(iss_a), .iss_b(iss_b), .iss_c(iss_c), .iss_i(iss_i),
        .alu_ld(alu_ld), .alu_div(alu_div), .alu_ir(alu_ir),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_i(alu_i),
        .alu_o(alu_o), .alu_mul_done(alu_mul_done), .alu_div_done(alu_div_done),
        .alu_div_dbz(alu_div_dbz), .alu_exc(alu_exc),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_res(wb_res),
        .wb_rid(wb_rid), .wb_exc(wb_exc)
    );

    typedef struct {
        alu_class_t   cls;
        logic         sgn;
        instruction_t ir;
        logic [63:0]  a, b, c, i;
        logic [4:0]   rid;
        logic [63:0]  val;    // what the ALU returns when it completes
        cause_code_t  exc;
        int           d;      // done strobe d cycles after alu_ld (MUL/DIV)
        logic         dbz;
        logic         stale;  // extra done pulses during EXEC
        int           rdly;   // cycles wb_ready held low in HOLD
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // Reference model: timing and results straight from the op rules.
    function automatic bit done_in_time(input vec_t v);
        return v.d >= 1 && v.d <= T;
    endfunction

    function automatic int exp_lat(input vec_t v);
        if (v.cls == SINGLE) return 2;
        return done_in_time(v) ? 2 + v.d : 2 + T;
    endfunction

    function automatic logic [63:0] exp_res(input vec_t v);
        if (v.cls == SINGLE || done_in_time(v)) return v.val;
        return {4{16'hDEAD}};
    endfunction

    function automatic cause_code_t exp_exc(input vec_t v);
        if (v.cls != SINGLE && !done_in_time(v)) return FLT_ALU_TO;
        if (v.cls == DIV && v.dbz) return FLT_DBZ;
        return v.exc;
    endfunction

    task automatic idle_alu();
        alu_o = r64(); alu_exc = FLT_ILL;
        alu_mul_done = 1'b0; alu_div_done = 1'b0; alu_div_dbz = 1'b0;
    endtask

    task automatic drive_issue(input vec_t v);
        iss_valid = 1'b1; iss_cls = v.cls; iss_sgn = v.sgn; iss_ir = v.ir;
        iss_rid = v.rid; iss_a = v.a; iss_b = v.b; iss_c = v.c; iss_i = v.i;
    endtask

    task automatic scramble_issue();
        iss_valid = 1'b0; iss_sgn = ~iss_sgn; iss_ir = $urandom; iss_rid = 5'($urandom);
        iss_a = r64(); iss_b = r64(); iss_c = r64(); iss_i = r64();
    endtask

    task automatic run_vec(input vec_t v);
        int got, lat;
        bit fin;
        logic [63:0] r0;
        logic [4:0] id0;
        cause_code_t e0;
        lat = exp_lat(v);
        got = -1;
        @(negedge clk);
        chk("iss_ready_idle", iss_ready, 1'b1);
        drive_issue(v);
        wb_ready = 1'b0;
        idle_alu();
        for (int c = 1; c <= lat + 2 && got < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                scramble_issue();
                chk("alu_ld_exec", alu_ld, 1'b1);
                chk("alu_a", alu_a, v.a);
                chk("alu_b", alu_b, v.b);
                chk("alu_c", alu_c, v.c);
                chk("alu_i", alu_i, v.i);
                chk("alu_ir", alu_ir, v.ir);
                chk("alu_div", alu_div, v.sgn);
            end
            if (c == 2) chk("alu_ld_pulse", alu_ld, 1'b0);
            if (wb_valid) begin
                got = c;
            end else begin
                fin = (v.cls == SINGLE) ? (c == 1) : (c == 1 + v.d);
                alu_o   = fin ? v.val : r64();
                alu_exc = fin ? v.exc : FLT_ILL;
                alu_div_dbz = fin ? v.dbz : 1'($urandom);
                alu_mul_done = (v.cls == MUL && c == 1 + v.d) || (v.stale && c == 1) ||
                               (v.cls == DIV && c == 2);
                alu_div_done = (v.cls == DIV && c == 1 + v.d) || (v.stale && c == 1) ||
                               (v.cls == MUL && c == 2);
            end
        end
        idle_alu();
        chk("wb_latency", got, lat);
        if (got < 0) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            return;
        end
        chk("wb_res", wb_res, exp_res(v));
        chk("wb_rid", wb_rid, v.rid);
        chk("wb_exc", wb_exc, exp_exc(v));
        r0 = wb_res; id0 = wb_rid; e0 = wb_exc;
        wb_ready = (v.rdly == 0);
        for (int k = 1; k <= v.rdly; k++) begin
            @(negedge clk);
            chk("hold_valid", wb_valid, 1'b1);
            chk("hold_res", wb_res, r0);
            chk("hold_rid", wb_rid, id0);
            chk("hold_exc", wb_exc, e0);
            chk("hold_iss_ready", iss_ready, 1'b0);
            if (k == v.rdly) wb_ready = 1'b1;
        end
        @(negedge clk);
        wb_ready = 1'b0;
        chk("post_wb_valid", wb_valid, 1'b0);
        chk("post_iss_ready", iss_ready, 1'b1);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
        iss_valid = 1'b0; iss_cls = SINGLE; iss_sgn = 1'b0; iss_ir = '0; iss_rid = '0;
        iss_a = '0; iss_b = '0; iss_c = '0; iss_i = '0;
        idle_alu();

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_iss_ready", iss_ready, 1'b1);
        chk("rst_alu_ld", alu_ld, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_exc", wb_exc, FLT_NONE);
        chk("rst_wb_res", wb_res, 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        rst = 1'b0;

        //          cls     sgn ir            a       b      c      i      rid    val                    exc       d      dbz   stale rdly
        tbl[0] = '{SINGLE, 0, 32'h0000_0013, 64'd5, 64'd0, 64'd0, 64'd3, 5'd7,  64'd8,                 FLT_NONE, 0,     1'b0, 1'b0, 0};
        tbl[1] = '{MUL,    0, 32'h0000_1033, 64'd6, 64'd7, 64'd0, 64'd0, 5'd3,  64'h1234_5678_9abc_def0, FLT_NONE, 4,     1'b0, 1'b1, 0};
        tbl[2] = '{DIV,    1, 32'h0000_2033, 64'd9, 64'd0, 64'd0, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, FLT_NONE, 3,     1'b1, 1'b0, 1};
        tbl[3] = '{DIV,    0, 32'h0000_3033, 64'd9, 64'd2, 64'd0, 64'd0, 5'd20, 64'd4,                 FLT_NONE, NEVER, 1'b0, 1'b1, 0};
        tbl[4] = '{SINGLE, 0, 32'h0000_4013, 64'd1, 64'd1, 64'd1, 64'd1, 5'd31, 64'hCAFE,              FLT_OFL,  0,     1'b0, 1'b0, 5};
        tbl[5] = '{DIV,    0, 32'h0000_5033, 64'd8, 64'd2, 64'd0, 64'd0, 5'd1,  64'd4,                 FLT_NONE, T,     1'b0, 1'b0, 0};
        tbl[6] = '{MUL,    1, 32'h0000_6033, 64'd2, 64'd3, 64'd0, 64'd0, 5'd9,  64'd6,                 FLT_OFL,  1,     1'b1, 1'b0, 2};
        tbl[7] = '{MUL,    0, 32'h0000_7033, 64'd2, 64'd3, 64'd0, 64'd0, 5'd10, 64'd6,                 FLT_NONE, T + 1, 1'b0, 1'b0, 0};
        foreach (tbl[n]) run_vec(tbl[n]);

        // flush mid-WAIT with a coincident done: op is dropped
        @(negedge clk);
        rv = tbl[2];
        drive_issue(rv);
        @(negedge clk); scramble_issue();
        @(negedge clk);
        @(negedge clk); flush = 1'b1; alu_div_done = 1'b1; alu_o = 64'd77;
        @(negedge clk); flush = 1'b0; idle_alu();
        chk("flush_wb_valid", wb_valid, 1'b0);
        chk("flush_iss_ready", iss_ready, 1'b1);
        chk("flush_alu_ld", alu_ld, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("flush_quiet", wb_valid, 1'b0);
        end

        // flush overrides accept
        drive_issue(tbl[0]); flush = 1'b1;
        @(negedge clk); flush = 1'b0; iss_valid = 1'b0;
        chk("flush_acc_ld", alu_ld, 1'b0);
        chk("flush_acc_ready", iss_ready, 1'b1);

        // reset mid-WAIT abandons the op
        drive_issue(tbl[1]);
        @(negedge clk); scramble_issue();
        @(negedge clk);
        @(negedge clk); rst = 1'b1; alu_mul_done = 1'b1;
        @(negedge clk); rst = 1'b0; idle_alu();
        chk("rstw_wb_valid", wb_valid, 1'b0);
        chk("rstw_iss_ready", iss_ready, 1'b1);
        chk("rstw_wb_res", wb_res, 64'd0);
        chk("rstw_wb_exc", wb_exc, FLT_NONE);
        chk("rstw_alu_a", alu_a, 64'd0);

        // randomized ops against the model
        for (int n = 0; n < 40; n++) begin
            rv.cls   = alu_class_t'($urandom_range(0, 2));
            rv.sgn   = 1'($urandom);
            rv.ir    = $urandom;
            rv.a     = r64(); rv.b = r64(); rv.c = r64(); rv.i = r64();
            rv.rid   = 5'($urandom);
            rv.val   = r64();
            rv.exc   = ($urandom_range(0, 1) == 0) ? FLT_NONE : FLT_OFL;
            rv.d     = $urandom_range(0, T + 3);
            rv.dbz   = 1'($urandom);
            rv.stale = 1'($urandom);
            rv.rdly  = $urandom_range(0, 3);
            run_vec(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
